// File: rtl/aquila_bus_pkg.sv
// Shared data-bus constants for the Aquila routers: FSM encoding, default
// segment values and the read value returned on a bus error.
package aquila_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    localparam logic [3:0] SEG_TCM   = 4'h0;
    localparam logic [3:0] SEG_DDR   = 4'h8;
    localparam logic [3:0] SEG_DEV   = 4'hC;
    localparam logic [3:0] SEG_CLINT = 4'hF;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/aquila_dbus_router_if.sv
// Core-side and slave-side data-bus signals of the router.
// The router uses the slave modport; the core plus slave environment uses master.
interface aquila_dbus_router_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_SLAVES   = 4
);
    logic                           p_req_i;
    logic                           p_rw_i;
    logic [ADDR_WIDTH-1:0]          p_addr_i;
    logic [DATA_WIDTH/8-1:0]        p_byte_enable_i;
    logic [DATA_WIDTH-1:0]          p_data_i;
    logic [DATA_WIDTH-1:0]          p_data_o;
    logic                           p_ready_o;
    logic                           p_err_o;

    logic [N_SLAVES-1:0]            s_req_o;
    logic [N_SLAVES-1:0]            s_strobe_o;
    logic [N_SLAVES-1:0]            s_rw_o;
    logic [ADDR_WIDTH-1:0]          s_addr_o;
    logic [DATA_WIDTH/8-1:0]        s_byte_enable_o;
    logic [DATA_WIDTH-1:0]          s_data_o;
    logic [N_SLAVES*DATA_WIDTH-1:0] s_data_i;
    logic [N_SLAVES-1:0]            s_ready_i;

    modport slave (
        input  p_req_i, p_rw_i, p_addr_i, p_byte_enable_i, p_data_i,
        output p_data_o, p_ready_o, p_err_o,
        output s_req_o, s_strobe_o, s_rw_o, s_addr_o, s_byte_enable_o, s_data_o,
        input  s_data_i, s_ready_i
    );

    modport master (
        output p_req_i, p_rw_i, p_addr_i, p_byte_enable_i, p_data_i,
        input  p_data_o, p_ready_o, p_err_o,
        input  s_req_o, s_strobe_o, s_rw_o, s_addr_o, s_byte_enable_o, s_data_o,
        output s_data_i, s_ready_i
    );

endinterface

// File: rtl/aquila_seg_decoder.sv
// Combinational address-segment to slave-index decoder, shared by the data
// and instruction routers. The lowest matching slot wins.
module aquila_seg_decoder #(
    parameter int                           SEG_BITS      = 4,
    parameter int                           N_SLAVES      = 4,
    parameter logic [N_SLAVES*SEG_BITS-1:0] SEG_MAP       = '0,
    parameter int                           DEFAULT_SLAVE = 1,
    parameter int                           IDX_W         = $clog2(N_SLAVES + 1)
) (
    input  logic [SEG_BITS-1:0] seg_i,
    output logic [IDX_W-1:0]    sel_o
);

    always_comb begin
        sel_o = IDX_W'(DEFAULT_SLAVE);
        // Walk downward so the lowest matching slot is the last to write.
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (seg_i == SEG_MAP[k*SEG_BITS +: SEG_BITS]) sel_o = IDX_W'(k);
        end
    end

endmodule

// File: rtl/aquila_dbus_router.sv
// Aquila data-bus router: segment decode, one-outstanding-transaction FSM and
// response routing. Define AQUILA_DBUS_TIMEOUT_EN to add the hung-slave watchdog.
module aquila_dbus_router
    import aquila_bus_pkg::*;
#(
    parameter int                           ADDR_WIDTH     = 32,
    parameter int                           DATA_WIDTH     = 32,
    parameter int                           N_SLAVES       = 4,
    parameter int                           SEG_BITS       = 4,
    parameter logic [N_SLAVES*SEG_BITS-1:0] SEG_MAP        = {SEG_CLINT, SEG_DEV, SEG_DDR, SEG_TCM},
    parameter int                           DEFAULT_SLAVE  = 1,
    parameter int                           TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    aquila_dbus_router_if.slave   bus,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(N_SLAVES + 1);

    if (N_SLAVES < 1 || N_SLAVES > 8) begin : g_bad_nslaves
        $error("aquila_dbus_router: N_SLAVES must be 1..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("aquila_dbus_router: TIMEOUT_CYCLES must be at least 2");
    end

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        sel_r_q, sel_r_d;
    logic [IDX_W-1:0]        sel;
    logic [N_SLAVES-1:0]     s_req, s_strobe;
    logic                    p_ready, p_err;
    logic [DATA_WIDTH-1:0]   p_data;
    logic                    any_req;

`ifdef AQUILA_DBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    aquila_seg_decoder #(
        .SEG_BITS      (SEG_BITS),
        .N_SLAVES      (N_SLAVES),
        .SEG_MAP       (SEG_MAP),
        .DEFAULT_SLAVE (DEFAULT_SLAVE),
        .IDX_W         (IDX_W)
    ) u_dec (
        .seg_i (bus.p_addr_i[ADDR_WIDTH-1 -: SEG_BITS]),
        .sel_o (sel)
    );

    always_comb begin
        state_d  = state_q;
        sel_r_d  = sel_r_q;
        s_req    = '0;
        s_strobe = '0;
        p_ready  = 1'b0;
        p_err    = 1'b0;
        p_data   = '0;
`ifdef AQUILA_DBUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.p_req_i) begin
                    if (sel < IDX_W'(N_SLAVES)) begin
                        for (int k = 0; k < N_SLAVES; k++) begin
                            if (sel == IDX_W'(k)) begin
                                s_req[k]    = 1'b1;
                                s_strobe[k] = 1'b1;
                            end
                        end
                        sel_r_d = sel;
                        state_d = ST_WAIT;
`ifdef AQUILA_DBUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_WAIT: begin
                for (int k = 0; k < N_SLAVES; k++) begin
                    if (sel_r_q == IDX_W'(k)) begin
                        s_req[k] = 1'b1;
                        p_data   = bus.s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                        p_ready  = bus.s_ready_i[k];
                    end
                end
                if (p_ready) begin
                    state_d = ST_IDLE;
`ifdef AQUILA_DBUS_TIMEOUT_EN
                // A ready in the terminal cycle still wins over the timeout.
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    s_req   = '0;
                    p_ready = 1'b1;
                    p_err   = 1'b1;
                    p_data  = DATA_WIDTH'(ERR_RDATA);
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_ERR: begin
                p_ready = 1'b1;
                p_err   = 1'b1;
                p_data  = DATA_WIDTH'(ERR_RDATA);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Keep every output quiet while reset is held, even with p_req_i high.
        if (rst_i) begin
            s_req    = '0;
            s_strobe = '0;
            p_ready  = 1'b0;
            p_err    = 1'b0;
            p_data   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_r_q <= '0;
`ifdef AQUILA_DBUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_r_q <= sel_r_d;
`ifdef AQUILA_DBUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign any_req             = |s_req;
    assign bus.s_req_o         = s_req;
    assign bus.s_strobe_o      = s_strobe;
    assign bus.s_rw_o          = {N_SLAVES{bus.p_rw_i}} & s_req;
    assign bus.s_addr_o        = any_req ? bus.p_addr_i : '0;
    assign bus.s_data_o        = any_req ? bus.p_data_i : '0;
    assign bus.s_byte_enable_o = any_req ? bus.p_byte_enable_i : '0;
    assign bus.p_ready_o       = p_ready;
    assign bus.p_err_o         = p_err;
    assign bus.p_data_o        = p_data;
    assign busy_o              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aquila_dbus_router.sv
// Directed bench for aquila_dbus_router: default-map instance plus an
// instance whose default slave is "unmapped".
module tb_aquila_dbus_router;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, ebusy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    aquila_dbus_router_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_SLAVES(4)) bif ();
    aquila_dbus_router_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_SLAVES(4)) eif ();

    aquila_dbus_router #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i (clk), .rst_i (rst), .bus (bif.slave), .busy_o (busy)
    );

    aquila_dbus_router #(.DEFAULT_SLAVE(4), .TIMEOUT_CYCLES(16)) dut_err (
        .clk_i (clk), .rst_i (rst), .bus (eif.slave), .busy_o (ebusy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.p_req_i = 0; bif.p_rw_i = 0; bif.p_addr_i = '0; bif.p_byte_enable_i = '0;
        bif.p_data_i = '0; bif.s_data_i = '0; bif.s_ready_i = '0;
        eif.p_req_i = 0; eif.p_rw_i = 0; eif.p_addr_i = '0; eif.p_byte_enable_i = '0;
        eif.p_data_i = '0; eif.s_data_i = '0; eif.s_ready_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bif.p_req_i = 1; bif.p_addr_i = 32'hC000_0000;
        #2;
        total++; if (bif.s_req_o !== 4'b0000) begin bad++; $display("FAIL reset_sreq: got %b want 0000", bif.s_req_o); end
        total++; if (bif.p_ready_o !== 1'b0 || bif.p_data_o !== 32'h0) begin bad++; $display("FAIL reset_pout: got rdy=%b data=%h want 0/0", bif.p_ready_o, bif.p_data_o); end
        total++; if (busy !== 1'b0 || bif.s_addr_o !== 32'h0) begin bad++; $display("FAIL reset_busy_addr: got busy=%b addr=%h want 0/0", busy, bif.s_addr_o); end
        bif.p_req_i = 0; bif.p_addr_i = '0;
        step(); step();
        rst = 0;
        step();
    endtask

    task automatic test_dev_read();
        bif.p_req_i = 1; bif.p_rw_i = 0; bif.p_addr_i = 32'hC000_0010; bif.p_byte_enable_i = 4'hF;
        #1;
        total++; if (bif.s_strobe_o !== 4'b0100 || bif.s_req_o !== 4'b0100) begin bad++; $display("FAIL rd_strobe: got stb=%b req=%b want 0100/0100", bif.s_strobe_o, bif.s_req_o); end
        total++; if (bif.s_addr_o !== 32'hC000_0010 || bif.s_rw_o !== 4'b0000) begin bad++; $display("FAIL rd_addr: got addr=%h rw=%b want c0000010/0000", bif.s_addr_o, bif.s_rw_o); end
        step();
        bif.s_ready_i = 4'b0001;
        #1;
        total++; if (bif.s_strobe_o !== 4'b0000 || bif.s_req_o !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL rd_wait: got stb=%b req=%b busy=%b want 0000/0100/1", bif.s_strobe_o, bif.s_req_o, busy); end
        total++; if (bif.p_ready_o !== 1'b0) begin bad++; $display("FAIL rd_foreign_ready: got %b want 0", bif.p_ready_o); end
        step();
        bif.s_ready_i = 4'b0000;
        step();
        bif.s_ready_i = 4'b0100;
        bif.s_data_i = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        #1;
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_err_o !== 1'b0) begin bad++; $display("FAIL rd_done: got rdy=%b err=%b want 1/0", bif.p_ready_o, bif.p_err_o); end
        total++; if (bif.p_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", bif.p_data_o); end
        step();
        bif.p_req_i = 0; bif.s_ready_i = '0;
        #1;
        total++; if (bif.p_ready_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_pulse: got rdy=%b busy=%b want 0/0", bif.p_ready_o, busy); end
    endtask

    task automatic test_tcm_write();
        bif.p_req_i = 1; bif.p_rw_i = 1; bif.p_addr_i = 32'h0000_0040;
        bif.p_byte_enable_i = 4'b0011; bif.p_data_i = 32'hA5A5_1234;
        bif.s_ready_i = 4'b0001;
        #1;
        total++; if (bif.s_rw_o !== 4'b0001 || bif.s_strobe_o !== 4'b0001) begin bad++; $display("FAIL wr_rw: got rw=%b stb=%b want 0001/0001", bif.s_rw_o, bif.s_strobe_o); end
        total++; if (bif.s_data_o !== 32'hA5A5_1234 || bif.s_byte_enable_o !== 4'b0011) begin bad++; $display("FAIL wr_data: got data=%h be=%b want a5a51234/0011", bif.s_data_o, bif.s_byte_enable_o); end
        total++; if (bif.p_ready_o !== 1'b0) begin bad++; $display("FAIL wr_strobe_ready: got %b want 0", bif.p_ready_o); end
        step();
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_err_o !== 1'b0 || bif.s_rw_o !== 4'b0001) begin bad++; $display("FAIL wr_done: got rdy=%b err=%b rw=%b want 1/0/0001", bif.p_ready_o, bif.p_err_o, bif.s_rw_o); end
        step();
        bif.p_req_i = 0; bif.s_ready_i = '0;
        #1;
        total++; if (bif.s_rw_o !== 4'b0000 || bif.s_addr_o !== 32'h0 || bif.s_data_o !== 32'h0) begin bad++; $display("FAIL wr_gate: got rw=%b addr=%h data=%h want 0", bif.s_rw_o, bif.s_addr_o, bif.s_data_o); end
        bif.p_rw_i = 0; bif.p_data_i = '0; bif.p_byte_enable_i = '0;
    endtask

    task automatic test_default_slave();
        bif.p_req_i = 1; bif.p_addr_i = 32'h5000_0000;
        #1;
        total++; if (bif.s_strobe_o !== 4'b0010) begin bad++; $display("FAIL dflt_strobe: got %b want 0010", bif.s_strobe_o); end
        step();
        bif.s_ready_i = 4'b0010; bif.s_data_i = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
        #1;
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_data_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL dflt_data: got rdy=%b data=%h want 1/cafef00d", bif.p_ready_o, bif.p_data_o); end
        step();
        bif.p_req_i = 0; bif.s_ready_i = '0;
    endtask

    task automatic test_unmapped();
        eif.p_req_i = 1; eif.p_addr_i = 32'h5000_0000;
        eif.s_data_i = {4{32'h7777_7777}};
        #1;
        total++; if (eif.s_req_o !== 4'b0000 || eif.s_strobe_o !== 4'b0000 || eif.p_ready_o !== 1'b0) begin bad++; $display("FAIL unm_noreq: got req=%b stb=%b rdy=%b want 0", eif.s_req_o, eif.s_strobe_o, eif.p_ready_o); end
        step();
        total++; if (eif.p_ready_o !== 1'b1 || eif.p_err_o !== 1'b1 || eif.p_data_o !== 32'h0) begin bad++; $display("FAIL unm_err: got rdy=%b err=%b data=%h want 1/1/0", eif.p_ready_o, eif.p_err_o, eif.p_data_o); end
        step();
        eif.p_req_i = 0;
        #1;
        total++; if (eif.p_ready_o !== 1'b0 || ebusy !== 1'b0) begin bad++; $display("FAIL unm_pulse: got rdy=%b busy=%b want 0/0", eif.p_ready_o, ebusy); end
        eif.s_data_i = '0;
    endtask

    task automatic test_back_to_back();
        bif.p_req_i = 1; bif.p_addr_i = 32'h8000_0000;
        bif.s_data_i = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
        #1;
        total++; if (bif.s_strobe_o !== 4'b0010) begin bad++; $display("FAIL b2b_stb1: got %b want 0010", bif.s_strobe_o); end
        step();
        bif.s_ready_i = 4'b0010;
        #1;
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_data_o !== 32'h1111_0001) begin bad++; $display("FAIL b2b_rsp1: got rdy=%b data=%h want 1/11110001", bif.p_ready_o, bif.p_data_o); end
        step();
        bif.p_addr_i = 32'hF000_0000; bif.s_ready_i = '0;
        #1;
        total++; if (bif.s_strobe_o !== 4'b1000 || busy !== 1'b0) begin bad++; $display("FAIL b2b_stb2: got stb=%b busy=%b want 1000/0", bif.s_strobe_o, busy); end
        step();
        bif.s_ready_i = 4'b1000;
        #1;
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_data_o !== 32'h3333_0003) begin bad++; $display("FAIL b2b_rsp2: got rdy=%b data=%h want 1/33330003", bif.p_ready_o, bif.p_data_o); end
        step();
        bif.p_req_i = 0; bif.s_ready_i = '0; bif.s_data_i = '0;
        #1;
    endtask

    task automatic test_timeout();
        int early = 0;
        bif.p_req_i = 1; bif.p_addr_i = 32'hC000_0000;
        bif.s_data_i = {32'h0, 32'h5555_AAAA, 32'h0, 32'h0};
        step();
`ifdef AQUILA_DBUS_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            if (bif.p_ready_o !== 1'b0 || bif.s_req_o !== 4'b0100) early++;
            step();
        end
        total++; if (early !== 0) begin bad++; $display("FAIL to_early: got %0d bad wait cycles want 0", early); end
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_err_o !== 1'b1 || bif.p_data_o !== 32'h0) begin bad++; $display("FAIL to_err: got rdy=%b err=%b data=%h want 1/1/0", bif.p_ready_o, bif.p_err_o, bif.p_data_o); end
        total++; if (bif.s_req_o !== 4'b0000) begin bad++; $display("FAIL to_drop: got %b want 0000", bif.s_req_o); end
        step();
        bif.p_req_i = 0; bif.s_ready_i = 4'b0100;
        #1;
        total++; if (bif.p_ready_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_late: got rdy=%b busy=%b want 0/0", bif.p_ready_o, busy); end
`else
        for (int i = 1; i < 40; i++) begin
            if (bif.p_ready_o !== 1'b0 || bif.s_req_o !== 4'b0100 || busy !== 1'b1) early++;
            step();
        end
        total++; if (early !== 0) begin bad++; $display("FAIL nto_hold: got %0d bad wait cycles want 0", early); end
        bif.s_ready_i = 4'b0100;
        #1;
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_err_o !== 1'b0 || bif.p_data_o !== 32'h5555_AAAA) begin bad++; $display("FAIL nto_done: got rdy=%b err=%b data=%h want 1/0/5555aaaa", bif.p_ready_o, bif.p_err_o, bif.p_data_o); end
        step();
        bif.p_req_i = 0;
`endif
        bif.s_ready_i = '0; bif.s_data_i = '0;
        step();
    endtask

    task automatic test_reset_mid();
        bif.p_req_i = 1; bif.p_rw_i = 1; bif.p_addr_i = 32'hC000_0020; bif.p_data_i = 32'h1234_5678;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre: got busy=%b want 1", busy); end
        bif.s_ready_i = 4'b0100; bif.s_data_i = {4{32'h9999_9999}};
        rst = 1;
        #1;
        total++; if (bif.s_req_o !== 4'b0000 || bif.s_strobe_o !== 4'b0000 || bif.s_rw_o !== 4'b0000) begin bad++; $display("FAIL rst_sreq: got req=%b stb=%b rw=%b want 0", bif.s_req_o, bif.s_strobe_o, bif.s_rw_o); end
        total++; if (bif.p_ready_o !== 1'b0 || bif.p_data_o !== 32'h0 || bif.s_addr_o !== 32'h0 || bif.s_data_o !== 32'h0 || busy !== 1'b0) begin bad++; $display("FAIL rst_outs: got rdy=%b data=%h addr=%h wdata=%h busy=%b want 0", bif.p_ready_o, bif.p_data_o, bif.s_addr_o, bif.s_data_o, busy); end
        bif.s_ready_i = '0;
        step();
        rst = 0;
        #1;
        total++; if (bif.s_strobe_o !== 4'b0100) begin bad++; $display("FAIL rst_fresh: got %b want 0100", bif.s_strobe_o); end
        step();
        bif.s_ready_i = 4'b0100;
        #1;
        total++; if (bif.p_ready_o !== 1'b1 || bif.p_data_o !== 32'h9999_9999) begin bad++; $display("FAIL rst_complete: got rdy=%b data=%h want 1/99999999", bif.p_ready_o, bif.p_data_o); end
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_dev_read();
        test_tcm_write();
        test_default_slave();
        test_unmapped();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aquila_dbus_router.md
Name: aquila_dbus_router

Overview:
- Parametrised data-bus address decoder and response router between the Aquila core data port and N memory-mapped slaves (TCM, D-cache, device port, CLINT, and future slaves).
- Generalises the fixed 4-way segment decode into a configurable segment map.
- Tracks one outstanding transaction with an explicit FSM and generates the device strobe pulse.
- Returns a bus error for unmapped addresses and, optionally, for hung slaves.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width
N_SLAVES, 4, number of slave ports (1..8)
SEG_BITS, 4, number of address MSBs used for decode
SEG_MAP, {4'hF,4'hC,4'h8,4'h0}, flattened N_SLAVES*SEG_BITS; slot k holds slave k's segment value
DEFAULT_SLAVE, 1, slave index for addresses matching no slot; value N_SLAVES means "unmapped → error"
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
p_req_i  in  1  core request; address/rw/be/data held stable until p_ready_o
p_rw_i  in  1  1 = write
p_addr_i  in  ADDR_WIDTH  request address
p_byte_enable_i  in  DATA_WIDTH/8  write byte enables
p_data_i  in  DATA_WIDTH  write data
p_data_o  out  DATA_WIDTH  read data, valid when p_ready_o
p_ready_o  out  1  transaction complete, one-cycle pulse
p_err_o  out  1  error qualifier, valid with p_ready_o
s_req_o  out  N_SLAVES  per-slave level request
s_strobe_o  out  N_SLAVES  per-slave one-cycle start pulse
s_rw_o  out  N_SLAVES  per-slave write flag
s_addr_o  out  ADDR_WIDTH  shared address, zero when no slave is selected
s_byte_enable_o  out  DATA_WIDTH/8  shared byte enables
s_data_o  out  DATA_WIDTH  shared write data
s_data_i  in  N_SLAVES*DATA_WIDTH  flattened read data; slice k belongs to slave k
s_ready_i  in  N_SLAVES  per-slave completion
busy_o  out  1  FSM not in IDLE

Behaviour:
- Decode (combinational): seg = p_addr_i[ADDR_WIDTH-1 -: SEG_BITS]; sel = lowest k whose SEG_MAP slot equals seg, else DEFAULT_SLAVE.
- FSM states: IDLE, WAIT, ERR.
- IDLE, on p_req_i with sel < N_SLAVES:
  - s_req_o[sel]=1 and s_strobe_o[sel]=1 in the same cycle.
  - sel_r <= sel; next state WAIT.
- IDLE, on p_req_i with sel == N_SLAVES: no slave request; next state ERR.
- WAIT:
  - s_req_o[sel_r] stays high, strobe stays low.
  - p_data_o = s_data_i slice sel_r; p_ready_o = s_ready_i[sel_r].
  - On ready: return to IDLE.
- ERR: p_ready_o=1, p_err_o=1, p_data_o=0 for exactly one cycle, then IDLE. Unmapped latency is 1 cycle.
- Slave ready arriving in the strobe cycle is ignored: minimum slave latency is 1 cycle. Ready from any non-selected slave is ignored.
- Back-to-back requests: p_req_i high in the cycle after p_ready_o is treated as a new request in IDLE and produces a new strobe.
- s_rw_o[k] = p_rw_i && s_req_o[k]. s_addr_o and s_data_o are gated to 0 when no s_req_o bit is set.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE, sel_r=0, counter=0. All outputs 0. Any in-flight transaction is abandoned.

Optional Feature:
- Macro: AQUILA_DBUS_TIMEOUT_EN.
- Enabled:
  - A $clog2(TIMEOUT_CYCLES)-bit counter clears on entering WAIT and increments each WAIT cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 with no ready: p_ready_o=1, p_err_o=1, p_data_o=0, s_req_o dropped, return to IDLE.
  - Ready and timeout in the same cycle → normal completion, p_err_o=0.
- Disabled: no counter; WAIT persists until ready.

Decomposition:
- Package aquila_bus_pkg: FSM state encoding, default segment constants (SEG_TCM=0, SEG_DDR=8, SEG_DEV=C, SEG_CLINT=F), error read value.
- One sub-module, aquila_seg_decoder: a purely combinational parametrised address→index decoder, reused by the instruction-side router.

Test Plan:
- Read from 0xC000_0010, device ready after 3 cycles with 0xDEAD_BEEF → s_strobe_o=4'b0100 for one cycle, p_data_o=0xDEAD_BEEF, p_ready_o for 1 cycle, p_err_o=0.
- Write to 0x0000_0040, be=4'b0011, TCM ready after 1 cycle → s_rw_o=4'b0001, s_data_o equals p_data_i, p_ready_o asserted.
- DEFAULT_SLAVE=N_SLAVES, read from 0x5000_0000 → no s_req_o bit set; next cycle p_ready_o=1, p_err_o=1, p_data_o=0.
- Back-to-back requests 0x8000_0000 then 0xF000_0000 → two strobes, on bits 1 then 3; responses routed from the correct data slices.
- Timeout enabled, TIMEOUT_CYCLES=16, slave 2 never ready → error completion 16 cycles after the strobe; a late s_ready_i[2] is ignored.
- Assert rst_i in WAIT → all outputs 0 immediately; busy_o=0; first request after reset produces a fresh strobe.
